aes_key_sched_ctrl: RTL and testbench

Iterative AES-128 key-schedule controller. It accepts a cipher key over a valid/ready handshake and computes round keys 1–10 one per clock through a single shared SubWord unit. It stores all 11 round keys in a register bank and serves them to the round datapath through a registered indexed read port. It replaces the fully unrolled combinational expansion wherever area matters more than the 10-cycle setup latency.

---
 rtl/aes_key_pkg.sv | 21 ++
 rtl/aes_sbox.sv | 32 +++
 rtl/aes_subword.sv | 19 +
 rtl/aes_key_sched_ctrl.sv | 147 ++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_key_pkg.sv
// Shared definitions for the iterative AES-128 key-schedule controller:
// round count, bank depth, FSM state type, round-key type and GF(2^8) xtime.
package aes_key_pkg;

    localparam int NR         = 10;
    localparam int BANK_DEPTH = NR + 1;

    typedef logic [127:0] round_key_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, one byte, purely combinational table lookup.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Entry 0 sits in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Table lookup.
    always_comb begin
        out_byte = SBOX_TABLE[(255 - int'(in_byte)) * 8 +: 8];
    end

endmodule

// File: rtl/aes_subword.sv
// SubWord(RotWord(w)) for the key schedule: rotate left by one byte,
// then substitute each byte through its own S-box.
module aes_subword (
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    logic [31:0] rot_word;

    assign rot_word = {word_in[23:0], word_in[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (rot_word[8*g +: 8]),
            .out_byte (word_out[8*g +: 8])
        );
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule controller. A key accepted over the
// key_valid/key_ready handshake is expanded one round key per clock through
// a single SubWord unit into an 11-entry bank, which is then served through
// a registered indexed read port.
// Optional build macro: AES_KEY_SCHED_ZEROIZE_EN adds the zeroize input,
// which wipes the bank and returns the controller to IDLE.
module aes_key_sched_ctrl #(
    parameter int NR = aes_key_pkg::NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         keys_valid,
    input  logic         rd_en,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_data,
    output logic         rd_valid
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    ,
    input  logic         zeroize
`endif
);

    import aes_key_pkg::*;

    localparam int DEPTH = NR + 1;

    state_t     state;
    state_t     state_nxt;
    round_key_t bank [DEPTH];
    round_key_t prev;
    round_key_t next_key;
    logic [3:0] rnd;
    logic [7:0] rcon;
    logic [31:0] sub_word;
    logic [31:0] temp;
    logic [31:0] w0_n, w1_n, w2_n, w3_n;
    logic        accept;
    logic        last_rnd;
    logic        idx_ok;

`ifdef AES_KEY_SCHED_ZEROIZE_EN
    logic wipe;
    assign wipe = zeroize;
`else
    localparam logic wipe = 1'b0;
`endif

    // A wipe request wins over a simultaneous handshake; that key is dropped.
    assign accept   = key_valid && key_ready && !wipe;
    assign last_rnd = (rnd == 4'(NR));
    assign idx_ok   = (rd_idx <= 4'(NR));

    aes_subword u_subword (
        .word_in  (prev[31:0]),
        .word_out (sub_word)
    );

    assign temp     = sub_word ^ {rcon, 24'h0};
    assign w0_n     = prev[127:96] ^ temp;
    assign w1_n     = w0_n ^ prev[95:64];
    assign w2_n     = w1_n ^ prev[63:32];
    assign w3_n     = w2_n ^ prev[31:0];
    assign next_key = {w0_n, w1_n, w2_n, w3_n};

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        if (wipe) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept)   state_nxt = EXPAND;
                EXPAND:  if (last_rnd) state_nxt = DONE;
                DONE:    if (accept)   state_nxt = EXPAND;
                default:               state_nxt = IDLE;
            endcase
        end
    end

    // FSM outputs: the handshake is closed only while expanding.
    always_comb begin
        key_ready = (state != EXPAND);
        busy      = (state == EXPAND);
    end

    // Key load, round-key generation and bank update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
            prev       <= '0;
            rnd        <= 4'd0;
            rcon       <= 8'h01;
            keys_valid <= 1'b0;
        end else if (wipe) begin
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
            prev       <= '0;
            rnd        <= 4'd0;
            rcon       <= 8'h01;
            keys_valid <= 1'b0;
        end else if (accept) begin
            bank[0]    <= key_in;
            prev       <= key_in;
            rnd        <= 4'd1;
            rcon       <= 8'h01;
            keys_valid <= 1'b0;
        end else if (state == EXPAND) begin
            bank[rnd] <= next_key;
            prev      <= next_key;
            rcon      <= xtime(rcon);
            if (last_rnd) begin
                keys_valid <= 1'b1;
            end else begin
                rnd <= rnd + 4'd1;
            end
        end
    end

    // Registered read port; out-of-range indices return zero, never valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (wipe) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            rd_data  <= idx_ok ? bank[rd_idx] : '0;
            rd_valid <= keys_valid && idx_ok;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Testbench for aes_key_sched_ctrl: FIPS-197 and all-zero vectors from a
// table, random keys against a word-level key-expansion model whose S-box is
// derived from GF(2^8) inversion plus the affine map, and hand-written
// sequences for busy handshakes, reload, async reset and zeroize.
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         keys_valid;
    logic         rd_en;
    logic [3:0]   rd_idx;
    logic [127:0] rd_data;
    logic         rd_valid;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    logic         zeroize;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_ref [256];
    logic [127:0] ref_rk [11];

    typedef struct {
        logic [127:0] key;
        logic [3:0]   idx;
        logic [127:0] exp_data;
        logic         exp_valid;
    } vec_t;

    vec_t tbl [6];

    aes_key_sched_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rd_en      (rd_en),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid)
`ifdef AES_KEY_SCHED_ZEROIZE_EN
        ,
        .zeroize    (zeroize)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // FIPS-197 word-oriented expansion into 44 words, then grouped per round.
    task automatic expand_ref(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]],
                     sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic accept_only(input logic [127:0] k);
        @(negedge clk);
        key_in    = k;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    // Called just after the accept edge; counts edges until keys_valid.
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!keys_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, n, 10);
        check({tag, " key_ready after done"}, key_ready, 1'b1);
    endtask

    task automatic load_key(input logic [127:0] k, input string tag);
        accept_only(k);
        wait_done(tag);
    endtask

    task automatic do_read(input logic [3:0] idx, output logic [127:0] d,
                           output logic v);
        @(negedge clk);
        rd_en  = 1'b1;
        rd_idx = idx;
        @(posedge clk);
        #1;
        d     = rd_data;
        v     = rd_valid;
        rd_en = 1'b0;
    endtask

    initial begin
        logic [127:0] d;
        logic         v;
        logic [127:0] key_a, key_b, key_c, key_d, key_e, k;
        logic [127:0] old_rk10;

        rst       = 1'b1;
        key_in    = '0;
        key_valid = 1'b0;
        rd_en     = 1'b0;
        rd_idx    = 4'd0;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
        zeroize   = 1'b0;
`endif

        tbl[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd1,
                   128'ha0fafe1788542cb123a339392a6c7605, 1'b1};
        tbl[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd10,
                   128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1};
        tbl[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd0,
                   128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1};
        tbl[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd12,
                   128'h0, 1'b0};
        tbl[4] = '{128'h0, 4'd1,
                   128'h62636363626363636263636362636363, 1'b1};
        tbl[5] = '{128'h0, 4'd10,
                   128'hb4ef5bcb3e92e21123e951cf6f8f188e, 1'b1};

        build_sbox();

        #1;
        check("reset key_ready", key_ready, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset keys_valid", keys_valid, 1'b0);
        check("reset rd_valid", rd_valid, 1'b0);
        check("reset rd_data", rd_data, 128'h0);
        @(negedge clk);
        rst = 1'b0;

        // Known-answer vectors.
        for (int i = 0; i < 6; i++) begin
            load_key(tbl[i].key, $sformatf("tbl%0d", i));
            do_read(tbl[i].idx, d, v);
            check($sformatf("tbl%0d rd_data", i), d, tbl[i].exp_data);
            check($sformatf("tbl%0d rd_valid", i), v, tbl[i].exp_valid);
        end

        // Second key presented while expanding is ignored.
        key_a = {$urandom, $urandom, $urandom, $urandom};
        key_b = {$urandom, $urandom, $urandom, $urandom};
        accept_only(key_a);
        @(negedge clk);
        key_in    = key_b;
        key_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("held key key_ready", key_ready, 1'b0);
        check("held key busy", busy, 1'b1);
        @(negedge clk);
        key_valid = 1'b0;
        key_in    = '0;
        begin
            int n;
            n = 0;
            while (!keys_valid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("held key done", keys_valid, 1'b1);
        end
        expand_ref(key_a);
        do_read(4'd0, d, v);
        check("held key bank0", d, key_a);
        do_read(4'd10, d, v);
        check("held key bank10", d, ref_rk[10]);
        old_rk10 = ref_rk[10];

        // Reload in DONE with a read on the same edge.
        key_c = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        key_in    = key_c;
        key_valid = 1'b1;
        rd_en     = 1'b1;
        rd_idx    = 4'd10;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        rd_en     = 1'b0;
        check("reload read data", rd_data, old_rk10);
        check("reload read valid", rd_valid, 1'b1);
        check("reload keys_valid drop", keys_valid, 1'b0);
        check("reload busy", busy, 1'b1);
        wait_done("reload");
        expand_ref(key_c);
        for (int i = 0; i < 11; i++) begin
            do_read(4'(i), d, v);
            check($sformatf("reload rk%0d", i), d, ref_rk[i]);
        end

        // Read during expansion, then async reset at E5.
        key_d = {$urandom, $urandom, $urandom, $urandom};
        accept_only(key_d);
        do_read(4'd0, d, v);
        check("expand read data", d, key_d);
        check("expand read valid", v, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst key_ready", key_ready, 1'b1);
        check("midrst busy", busy, 1'b0);
        check("midrst keys_valid", keys_valid, 1'b0);
        check("midrst rd_valid", rd_valid, 1'b0);
        check("midrst rd_data", rd_data, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        do_read(4'd1, d, v);
        check("midrst bank1 cleared", d, 128'h0);
        check("midrst bank1 valid", v, 1'b0);
        key_e = {$urandom, $urandom, $urandom, $urandom};
        load_key(key_e, "post-reset");
        expand_ref(key_e);
        do_read(4'd5, d, v);
        check("post-reset rk5", d, ref_rk[5]);
        check("post-reset rk5 valid", v, 1'b1);

        // Random keys against the reference model.
        for (int r = 0; r < 5; r++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            load_key(k, $sformatf("rand%0d", r));
            expand_ref(k);
            for (int i = 0; i < 11; i++) begin
                do_read(4'(i), d, v);
                check($sformatf("rand%0d rk%0d", r, i), d, ref_rk[i]);
                check($sformatf("rand%0d rk%0d valid", r, i), v, 1'b1);
            end
            do_read(4'($urandom_range(11, 15)), d, v);
            check($sformatf("rand%0d oob data", r), d, 128'h0);
            check($sformatf("rand%0d oob valid", r), v, 1'b0);
        end

`ifdef AES_KEY_SCHED_ZEROIZE_EN
        // Zeroize in DONE beats a simultaneous key handshake and read.
        @(negedge clk);
        zeroize   = 1'b1;
        key_valid = 1'b1;
        key_in    = {$urandom, $urandom, $urandom, $urandom};
        rd_en     = 1'b1;
        rd_idx    = 4'd3;
        @(posedge clk);
        #1;
        zeroize   = 1'b0;
        key_valid = 1'b0;
        rd_en     = 1'b0;
        check("zeroize keys_valid", keys_valid, 1'b0);
        check("zeroize rd_valid", rd_valid, 1'b0);
        check("zeroize rd_data", rd_data, 128'h0);
        check("zeroize key_ready", key_ready, 1'b1);
        check("zeroize busy", busy, 1'b0);
        @(posedge clk);
        #1;
        check("zeroize key dropped", busy, 1'b0);
        do_read(4'd0, d, v);
        check("zeroize bank0", d, 128'h0);
        check("zeroize bank0 valid", v, 1'b0);
        do_read(4'd10, d, v);
        check("zeroize bank10", d, 128'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
